// File: rtl/jogo_rodadas_unidade_controle.sv
// ---------------------------------------------------------------------------
// jogo_rodadas_unidade_controle
//
// Moore control unit for the memory game. The game runs in rounds. In round N
// the player must replay plays 0..N, one play per memory address. This block
// drives the address counter (E), the round/limit counter (L) and the play
// register (R). It reports a win, a wrong play, or an inactivity timeout.
//
// Optional feature macro: JOGO_TIMEOUT_EN
//   defined   : an inactivity timer runs in espera_jogada. After
//               TIMEOUT_CYCLES cycles without a play the game ends in
//               fim_timeout.
//   undefined : no timer exists and espera_jogada waits forever. o_timeout
//               is tied to 0, and state code D counts as an illegal code.
//
// Parameters
//   TIMEOUT_CYCLES : cycles allowed in espera_jogada (>= 2)
//   TMR_W          : timer width, 2**TMR_W > TIMEOUT_CYCLES
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_iniciar      start / restart request (level)
//   i_jogada       one-cycle pulse, player made a play
//   i_igual        registered play matches memory[E]
//   i_fim_jogada   E == L, last play of the current round
//   i_fim_rodada   L == last round
//   o_zeraE/o_contaE   clear / increment address counter
//   o_zeraL/o_contaL   clear / increment round counter
//   o_zeraR/o_registraR clear / load play register
//   o_acertou, o_errou, o_timeout  end-of-game causes
//   o_pronto       game over (any end state)
//   o_db_estado    current state code
//
// state          | code | meaning
// ---------------+------+------------------------------------------------
// inicial        |  0   | idle, waiting for iniciar
// preparacao     |  1   | clear counters and play register
// inicia_rodada  |  2   | restart address counter for a new round
// espera_jogada  |  4   | waiting for the player's play
// registra       |  5   | load the play register
// compara        |  6   | evaluate comparator / end-of-round flags
// proxima_jogada |  7   | advance address counter
// proxima_rodada |  8   | advance round counter
// fim_acertos    |  C   | all rounds replayed correctly
// fim_timeout    |  D   | player took too long
// fim_erro       |  E   | wrong play
// ---------------------------------------------------------------------------
module jogo_rodadas_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TMR_W          = 13
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_iniciar,
    input  logic       i_jogada,
    input  logic       i_igual,
    input  logic       i_fim_jogada,
    input  logic       i_fim_rodada,
    output logic       o_zeraE,
    output logic       o_contaE,
    output logic       o_zeraL,
    output logic       o_contaL,
    output logic       o_zeraR,
    output logic       o_registraR,
    output logic       o_acertou,
    output logic       o_errou,
    output logic       o_timeout,
    output logic       o_pronto,
    output logic [3:0] o_db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h4,
        REGISTRA       = 4'h5,
        COMPARA        = 4'h6,
        PROXIMA_JOGADA = 4'h7,
        PROXIMA_RODADA = 4'h8,
        FIM_ACERTOS    = 4'hC,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_expirou;

    // An illegal parameter combination produces this empty named block. It
    // shows up in the elaborated hierarchy and keeps both parameters
    // referenced in every build.
    if (TIMEOUT_CYCLES < 2 || TMR_W < 2 ||
        (64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_parametros_invalidos
    end

`ifdef JOGO_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMR_ULTIMO = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_timer;

    // The timer counts only while waiting for a play. It clears in every
    // other state, so each visit to espera_jogada starts from 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (r_estado == ESPERA_JOGADA) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    assign w_expirou = (r_timer == TMR_ULTIMO);
`else
    assign w_expirou = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:        w_proximo = i_iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     w_proximo = INICIA_RODADA;
            INICIA_RODADA:  w_proximo = ESPERA_JOGADA;
            // A play in the same cycle as expiry takes priority over the timeout.
            ESPERA_JOGADA: begin
                if (i_jogada)       w_proximo = REGISTRA;
                else if (w_expirou) w_proximo = FIM_TIMEOUT;
                else                w_proximo = ESPERA_JOGADA;
            end
            REGISTRA:       w_proximo = COMPARA;
            COMPARA: begin
                if (!i_igual)          w_proximo = FIM_ERRO;
                else if (!i_fim_jogada) w_proximo = PROXIMA_JOGADA;
                else if (!i_fim_rodada) w_proximo = PROXIMA_RODADA;
                else                   w_proximo = FIM_ACERTOS;
            end
            PROXIMA_JOGADA: w_proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: w_proximo = INICIA_RODADA;
            FIM_ACERTOS:    w_proximo = i_iniciar ? PREPARACAO : FIM_ACERTOS;
            FIM_ERRO:       w_proximo = i_iniciar ? PREPARACAO : FIM_ERRO;
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT:    w_proximo = i_iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:        w_proximo = INICIAL;
        endcase
    end

    always_comb begin
        o_zeraE     = 1'b0;
        o_contaE    = 1'b0;
        o_zeraL     = 1'b0;
        o_contaL    = 1'b0;
        o_zeraR     = 1'b0;
        o_registraR = 1'b0;
        o_acertou   = 1'b0;
        o_errou     = 1'b0;
        o_timeout   = 1'b0;
        o_pronto    = 1'b0;
        o_db_estado = r_estado;

        o_zeraE     = (r_estado == INICIAL) || (r_estado == PREPARACAO) ||
                      (r_estado == INICIA_RODADA);
        o_zeraL     = (r_estado == INICIAL) || (r_estado == PREPARACAO);
        o_zeraR     = (r_estado == INICIAL) || (r_estado == PREPARACAO);
        o_registraR = (r_estado == REGISTRA);
        o_contaE    = (r_estado == PROXIMA_JOGADA);
        o_contaL    = (r_estado == PROXIMA_RODADA);
        o_acertou   = (r_estado == FIM_ACERTOS);
        o_errou     = (r_estado == FIM_ERRO);
`ifdef JOGO_TIMEOUT_EN
        o_timeout   = (r_estado == FIM_TIMEOUT);
`endif
        o_pronto    = o_acertou | o_errou | o_timeout;
    end

endmodule

// File: tb/tb_jogo_rodadas_unidade_controle.sv
`timescale 1ns/1ps
module tb_jogo_rodadas_unidade_controle;

    localparam int TO = 10;

    // Stimulus row: {reset, iniciar, jogada, igual, fim_jogada, fim_rodada}
    // followed by the state expected after the clock edge.
    localparam logic [5:0] N = 6'b000000;
    localparam logic [5:0] R = 6'b100000;
    localparam logic [5:0] I = 6'b010000;
    localparam logic [5:0] J = 6'b001000;
    localparam logic [5:0] G = 6'b000100;
    localparam logic [5:0] F = 6'b000010;
    localparam logic [5:0] L = 6'b000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, jogada = 1'b0, igual = 1'b0;
    logic fim_jogada = 1'b0, fim_rodada = 1'b0;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic acertou, errou, timeout, pronto;
    logic [3:0] db_estado;

    int total = 0;
    int bad = 0;
    int n_reg = 0;
    int n_jog = 0;
    logic [13:0] sb[$];

    always #5 clk = ~clk;

    jogo_rodadas_unidade_controle #(.TIMEOUT_CYCLES(TO), .TMR_W(13)) dut (
        .i_clock(clk), .i_reset(reset), .i_iniciar(iniciar), .i_jogada(jogada),
        .i_igual(igual), .i_fim_jogada(fim_jogada), .i_fim_rodada(fim_rodada),
        .o_zeraE(zeraE), .o_contaE(contaE), .o_zeraL(zeraL), .o_contaL(contaL),
        .o_zeraR(zeraR), .o_registraR(registraR), .o_acertou(acertou),
        .o_errou(errou), .o_timeout(timeout), .o_pronto(pronto),
        .o_db_estado(db_estado)
    );

    // Expected Moore outputs for a given state code.
    function automatic logic [13:0] exp_out(input logic [3:0] s);
        logic ze, ce, zl, cl, zr, rr, ac, er, tm;
        ze = (s == 4'h0) || (s == 4'h1) || (s == 4'h2);
        zl = (s == 4'h0) || (s == 4'h1);
        zr = zl;
        rr = (s == 4'h5);
        ce = (s == 4'h7);
        cl = (s == 4'h8);
        ac = (s == 4'hC);
        er = (s == 4'hE);
        tm = (s == 4'hD);
        return {ze, ce, zl, cl, zr, rr, ac, er, tm, ac | er | tm, s};
    endfunction

    function automatic logic [13:0] observed();
        return {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                acertou, errou, timeout, pronto, db_estado};
    endfunction

    task automatic drive(input logic [9:0] row);
        @(negedge clk);
        {reset, iniciar, jogada, igual, fim_jogada, fim_rodada} = row[9:4];
        sb.push_back(exp_out(row[3:0]));
        if (row[3:0] == 4'h5) n_jog++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] seq[$];
        logic [13:0] got, exp;
        seq = '{{R,4'h0}, {J,4'h0}, {I,4'h1}, {N,4'h2}, {I,4'h4}, {N,4'h4},
                {R|J|I,4'h0}, {I,4'h1}, {N,4'h2}, {N,4'h4}};
        foreach (seq[i]) begin
            drive(seq[i]);
            got = observed();
            exp = sb.pop_front();
            if (got[8]) n_reg++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset step %0d: got=%h need=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_win();
        logic [9:0] seq[$];
        logic [13:0] got, exp;
        seq = '{{J,4'h5}, {J,4'h6}, {G|F,4'h8}, {J,4'h2}, {N,4'h4},
                {J,4'h5}, {N,4'h6}, {G,4'h7}, {N,4'h4},
                {J,4'h5}, {N,4'h6}, {G|F|L,4'hC}, {J,4'hC}, {N,4'hC},
                {I,4'h1}, {N,4'h2}, {N,4'h4}};
        foreach (seq[i]) begin
            drive(seq[i]);
            got = observed();
            exp = sb.pop_front();
            if (got[8]) n_reg++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL win step %0d: got=%h need=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_miss();
        logic [9:0] seq[$];
        logic [13:0] got, exp;
        seq = '{{J,4'h5}, {N,4'h6}, {G|F,4'h8}, {N,4'h2}, {N,4'h4},
                {J,4'h5}, {N,4'h6}, {F|L,4'hE}, {J,4'hE}, {N,4'hE},
                {I,4'h1}, {N,4'h2}, {N,4'h4}};
        foreach (seq[i]) begin
            drive(seq[i]);
            got = observed();
            exp = sb.pop_front();
            if (got[8]) n_reg++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL miss step %0d: got=%h need=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_spurious();
        logic [9:0] seq[$];
        logic [13:0] got, exp;
        seq = '{{J,4'h5}, {J,4'h6}, {J|G,4'h7}, {J,4'h4},
                {J,4'h5}, {J,4'h6}, {J|G|F,4'h8}, {J,4'h2}, {J,4'h4}};
        foreach (seq[i]) begin
            drive(seq[i]);
            got = observed();
            exp = sb.pop_front();
            if (got[8]) n_reg++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL spurious step %0d: got=%h need=%h", i, got, exp);
            end
        end
    endtask

    // Entered with the FSM having just arrived in espera_jogada.
    task automatic test_timeout();
        logic [9:0] seq[$];
        logic [13:0] got, exp;
`ifdef JOGO_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) seq.push_back({N, 4'h4});
        seq.push_back({N, 4'hD});
        seq.push_back({N, 4'hD});
        seq.push_back({J, 4'hD});
        seq.push_back({I, 4'h1});
        seq.push_back({N, 4'h2});
        seq.push_back({N, 4'h4});
        // Tie: play arrives in the very cycle the timer reaches its limit.
        for (int k = 0; k < TO - 1; k++) seq.push_back({N, 4'h4});
        seq.push_back({J, 4'h5});
`else
        for (int k = 0; k < 1000; k++) seq.push_back({N, 4'h4});
        seq.push_back({J, 4'h5});
`endif
        seq.push_back({N, 4'h6});
        seq.push_back({G, 4'h7});
        seq.push_back({N, 4'h4});
        foreach (seq[i]) begin
            drive(seq[i]);
            got = observed();
            exp = sb.pop_front();
            if (got[8]) n_reg++;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL timeout step %0d: got=%h need=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_registra_count();
        total++;
        if (n_reg !== n_jog) begin
            bad++;
            $display("FAIL registra_count: got=%0d need=%0d", n_reg, n_jog);
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_miss();
        test_spurious();
        test_timeout();
        test_registra_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
